// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: scan scheduler for two 4-digit seven-segment groups.
// A CPU-written shadow register is committed to the displayed value only
// at frame boundaries. Digits are sequenced through a drive/blank cycle,
// and leading zeros can optionally be suppressed.
module tube_scan_ctrl #(
    parameter int DIV       = 15000,
    parameter int BLANK_CYC = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    input  logic        scan_en,
    input  logic        lz_en,
    output logic [3:0]  sel0,
    output logic [3:0]  sel1,
    output logic [3:0]  nib0,
    output logic [3:0]  nib1,
    output logic        blank0,
    output logic        blank1,
    output logic        sign_neg,
    output logic        frame_tick,
    output logic        pending,
    output logic [35:0] shown
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    localparam int CMAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_LD = CW'(DIV - 1);
    localparam logic [CW-1:0] BLK_LD = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

    logic [1:0]    state, state_n;
    logic [1:0]    d, d_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          commit;
    logic [35:0]   shadow, active;
    logic          lz_q;
    logic [3:0]    nib0_q, nib1_q;

    // Position p is suppressed when every digit from p upward is zero.
    function automatic logic lz_suppress(input logic [31:0] v, input logic [2:0] p);
        if (p == 3'd0)
            return 1'b0;
        return (v >> {p, 2'b00}) == 32'd0;
    endfunction

    // Next-state, digit index and dwell counter; commit marks frame entry.
    always_comb begin
        state_n = state;
        d_n     = d;
        cnt_n   = cnt;
        commit  = 1'b0;
        if (!scan_en) begin
            state_n = IDLE;
            d_n     = 2'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = DRIVE;
                    d_n     = 2'd0;
                    cnt_n   = DIV_LD;
                    commit  = 1'b1;
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        if (BLANK_CYC == 0) begin
                            d_n    = d + 2'd1;
                            cnt_n  = DIV_LD;
                            commit = (d == 2'd3);
                        end else begin
                            state_n = BLANK;
                            cnt_n   = BLK_LD;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_n = DRIVE;
                        d_n     = d + 2'd1;
                        cnt_n   = DIV_LD;
                        commit  = (d == 2'd3);
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    d_n     = 2'd0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State, shadow/active registers and bookkeeping flags.
    // active samples the pre-write shadow, so a write on the commit edge
    // lands in the following frame and leaves pending set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            d          <= 2'd0;
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            lz_q       <= 1'b0;
            nib0_q     <= 4'd0;
            nib1_q     <= 4'd0;
        end else begin
            state      <= state_n;
            d          <= d_n;
            cnt        <= cnt_n;
            frame_tick <= commit;
            lz_q       <= lz_en;
            nib0_q     <= nib0;
            nib1_q     <= nib1;
            if (commit)
                active <= shadow;
            if (wr_en) begin
                if (wr_hi)
                    shadow[35:32] <= wr_data[3:0];
                else
                    shadow[31:0] <= wr_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Digit select/nibble/blank decode from registered state; nibbles hold outside DRIVE.
    always_comb begin
        sel0   = 4'b0000;
        sel1   = 4'b0000;
        nib0   = nib0_q;
        nib1   = nib1_q;
        blank0 = 1'b1;
        blank1 = 1'b1;
        if (state == DRIVE) begin
            nib0 = active[{d, 2'b00} +: 4];
            nib1 = active[{1'b1, d, 2'b00} +: 4];
            if (!(lz_q && lz_suppress(active[31:0], {1'b0, d})))
                sel0 = 4'b0001 << d;
            if (!(lz_q && lz_suppress(active[31:0], {1'b1, d})))
                sel1 = 4'b0001 << d;
            blank0 = ~|sel0;
            blank1 = ~|sel1;
        end
    end

    assign sign_neg = active[31];
    assign shown    = active;

endmodule
